// File: rtl/pc_gen_pkg.sv
// pc_pkg: shared FSM states, increment and redirect-cause encodings for the fetch PC generator
package pc_pkg;

    typedef enum logic {PC_BOOT, PC_RUN} pc_state_e;

    localparam int PC_INCR = 4;

    typedef enum logic [2:0] {EXC, FLUSH, HOLD, RET, CALL, SEQ} pc_cause_e;

endpackage

// File: rtl/pc_gen_if.sv
// pc_gen_if: request and fetch-PC signals between the hazard/predecode side and pc_gen
interface pc_gen_if #(
    parameter int XLEN = 32
);
    logic            enable;
    logic            exc_valid;
    logic            flush_valid;
    logic [XLEN-1:0] flush_target;
    logic            call_valid;
    logic [XLEN-1:0] call_target;
    logic            ret_valid;
    logic [XLEN-1:0] pc_out;
    logic            pc_valid;
    logic            ras_empty;
    logic            ras_full;

    modport master (
        output enable, exc_valid, flush_valid, flush_target, call_valid, call_target, ret_valid,
        input  pc_out, pc_valid, ras_empty, ras_full
    );

    modport slave (
        input  enable, exc_valid, flush_valid, flush_target, call_valid, call_target, ret_valid,
        output pc_out, pc_valid, ras_empty, ras_full
    );
endinterface

// File: rtl/pc_gen_ras.sv
// pc_ras: circular return-address stack; a push when full overwrites the oldest entry
module pc_ras #(
    parameter int RAS_DEPTH = 4,
    parameter int XLEN      = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            push,
    input  logic            pop,
    input  logic [XLEN-1:0] push_data,
    input  logic            clr,
    output logic [XLEN-1:0] top,
    output logic            empty,
    output logic            full
);
    localparam int PW = $clog2(RAS_DEPTH);

    logic [XLEN-1:0] mem_q [RAS_DEPTH];
    logic [PW-1:0]   ptr_q, ptr_d, top_idx;
    logic [PW:0]     cnt_q, cnt_d;
    logic            do_pop;

    assign top_idx = ptr_q - 1'b1;
    assign do_pop  = pop && !empty;
    assign top     = mem_q[top_idx];
    assign empty   = cnt_q == '0;
    assign full    = cnt_q == (PW+1)'(RAS_DEPTH);

    // Pointer/count update; a simultaneous pop+push reuses the popped slot and leaves both unchanged
    always_comb begin
        ptr_d = ptr_q;
        cnt_d = cnt_q;
        if (clr) begin
            ptr_d = '0;
            cnt_d = '0;
        end else if (do_pop && !push) begin
            ptr_d = top_idx;
            cnt_d = cnt_q - 1'b1;
        end else if (push && !do_pop) begin
            ptr_d = ptr_q + 1'b1;
            cnt_d = full ? cnt_q : cnt_q + 1'b1;
        end
    end

    // Pointer and occupancy registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= '0;
            cnt_q <= '0;
        end else begin
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
        end
    end

    // Entry storage needs no reset since occupancy gates every read that matters
    always_ff @(posedge clk) begin
        if (push && !clr) mem_q[do_pop ? top_idx : ptr_q] <= push_data;
    end
endmodule

// File: rtl/pc_gen.sv
// pc_gen: IF-stage program counter with boot hold, prioritised redirects and optional RAS (macro PC_RAS_EN)
module pc_gen
    import pc_pkg::*;
#(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(32'h0000_0000),
    parameter logic [XLEN-1:0] EXC_VECTOR   = XLEN'(32'h0000_0080),
    parameter int              RAS_DEPTH    = 4,
    parameter int              BOOT_CYCLES  = 2
) (
    input logic     clk,
    input logic     rst,
    pc_gen_if.slave bus
);
    localparam int BW = $clog2(BOOT_CYCLES + 1);

    pc_state_e       state_q, state_d;
    logic [BW-1:0]   boot_q, boot_d;
    logic [XLEN-1:0] pc_q, pc_d, pc_seq, ret_tgt;
    pc_cause_e       cause;
    logic            run, take_ret, ras_empty, ras_full;

    function automatic logic [XLEN-1:0] align(input logic [XLEN-1:0] a);
        return {a[XLEN-1:2], 2'b00};
    endfunction

    assign run    = state_q == PC_RUN;
    assign pc_seq = pc_q + XLEN'(PC_INCR);

`ifdef PC_RAS_EN
    logic [XLEN-1:0] ras_top;

    assign take_ret = bus.ret_valid && !ras_empty;
    assign ret_tgt  = ras_top;

    pc_ras #(
        .RAS_DEPTH(RAS_DEPTH),
        .XLEN     (XLEN)
    ) u_ras (
        .clk      (clk),
        .rst      (rst),
        .push     (run && (cause == CALL || (cause == RET && bus.call_valid))),
        .pop      (run && cause == RET),
        .push_data(pc_seq),
        .clr      (run && cause == EXC),
        .top      (ras_top),
        .empty    (ras_empty),
        .full     (ras_full)
    );
`else
    assign take_ret  = 1'b0;
    assign ret_tgt   = pc_seq;
    assign ras_empty = 1'b1;
    assign ras_full  = 1'b0;
`endif

    // Boot sequencing: count BOOT_CYCLES edges, then run forever until the next reset
    always_comb begin
        state_d = state_q;
        boot_d  = boot_q;
        if (state_q == PC_BOOT) begin
            boot_d  = boot_q + 1'b1;
            state_d = boot_q == BW'(BOOT_CYCLES - 1) ? PC_RUN : PC_BOOT;
        end
    end

    // Redirect priority: exceptions and flushes win over a stall, a stall wins over predecode
    always_comb begin
        cause = bus.exc_valid   ? EXC   :
                bus.flush_valid ? FLUSH :
                !bus.enable     ? HOLD  :
                take_ret        ? RET   :
                bus.call_valid  ? CALL  : SEQ;
        pc_d  = !run            ? pc_q                  :
                cause == EXC    ? align(EXC_VECTOR)     :
                cause == FLUSH  ? align(bus.flush_target) :
                cause == HOLD   ? pc_q                  :
                cause == RET    ? align(ret_tgt)        :
                cause == CALL   ? align(bus.call_target) : pc_seq;
    end

    // State, boot counter and PC registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= PC_BOOT;
            boot_q  <= '0;
            pc_q    <= RESET_VECTOR;
        end else begin
            state_q <= state_d;
            boot_q  <= boot_d;
            pc_q    <= pc_d;
        end
    end

    assign bus.pc_out    = pc_q;
    assign bus.pc_valid  = run;
    assign bus.ras_empty = ras_empty;
    assign bus.ras_full  = ras_full;
endmodule

// File: tb/tb_pc_gen.sv
// tb_pc_gen: randomized and directed checks of pc_gen against a queue-based reference model
module tb_pc_gen;
    localparam logic [31:0] RST_V = 32'h0000_0000;
    localparam logic [31:0] EXC_V = 32'h0000_0080;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    logic [31:0] exp_pc;
    logic        exp_valid;
    int          boot_left;
    logic [31:0] ras_q[$];

    pc_gen_if #(.XLEN(32)) bus();

    pc_gen dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        exp_pc    = RST_V;
        exp_valid = 1'b0;
        boot_left = 2;
        ras_q.delete();
    endtask

    // Reference: apply the redirect rules to the current inputs for one clock edge
    task automatic model_step();
        logic [31:0] seq;
        seq = exp_pc + 32'd4;
        if (boot_left > 0) begin
            boot_left--;
            exp_valid = boot_left == 0;
        end else if (bus.exc_valid) begin
            exp_pc = EXC_V;
            ras_q.delete();
        end else if (bus.flush_valid) begin
            exp_pc = bus.flush_target & ~32'd3;
        end else if (!bus.enable) begin
            exp_pc = exp_pc;
`ifdef PC_RAS_EN
        end else if (bus.ret_valid && ras_q.size() > 0) begin
            exp_pc = ras_q.pop_back();
            if (bus.call_valid) ras_q.push_back(seq);
`endif
        end else if (bus.call_valid) begin
            exp_pc = bus.call_target & ~32'd3;
`ifdef PC_RAS_EN
            ras_q.push_back(seq);
            if (ras_q.size() > DEPTH) void'(ras_q.pop_front());
`endif
        end else begin
            exp_pc = seq;
        end
    endtask

    task automatic idle();
        bus.enable = 1'b1; bus.exc_valid = 1'b0; bus.flush_valid = 1'b0; bus.call_valid = 1'b0;
        bus.ret_valid = 1'b0; bus.flush_target = '0; bus.call_target = '0;
    endtask

    task automatic step();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic goto(input logic [31:0] a);
        idle();
        bus.flush_valid = 1'b1;
        bus.flush_target = a;
        step();
        idle();
    endtask

    task automatic test_reset();
        idle();
        rst = 1'b1;
        model_reset();
        #1;
        n_tests += 4;
        if (bus.pc_out !== RST_V) begin n_fail++; $display("FAIL reset_pc got %h want %h", bus.pc_out, RST_V); end
        if (bus.pc_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", bus.pc_valid); end
        if (bus.ras_empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty got %b want 1", bus.ras_empty); end
        if (bus.ras_full !== 1'b0) begin n_fail++; $display("FAIL reset_full got %b want 0", bus.ras_full); end
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            logic [31:0] want_pc;
            logic        want_v;
            step();
            want_pc = i < 2 ? 32'h0 : 32'(4 * (i - 1));
            want_v  = i >= 1;
            n_tests += 2;
            if (bus.pc_out !== want_pc) begin n_fail++; $display("FAIL boot_pc[%0d] got %h want %h", i, bus.pc_out, want_pc); end
            if (bus.pc_valid !== want_v) begin n_fail++; $display("FAIL boot_valid[%0d] got %b want %b", i, bus.pc_valid, want_v); end
        end
    endtask

    task automatic test_stall_flush();
        goto(32'h10);
        bus.enable = 1'b0;
        bus.flush_valid = 1'b1;
        bus.flush_target = 32'h203;
        step();
        n_tests++;
        if (bus.pc_out !== 32'h200) begin n_fail++; $display("FAIL stall_flush got %h want 00000200", bus.pc_out); end
        bus.flush_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            n_tests++;
            if (bus.pc_out !== 32'h200) begin n_fail++; $display("FAIL stall_hold[%0d] got %h want 00000200", i, bus.pc_out); end
        end
        idle();
    endtask

    task automatic test_exc();
        goto(32'h30);
        bus.call_valid = 1'b1;
        bus.call_target = 32'h40;
        step();
        idle();
        bus.exc_valid = 1'b1;
        bus.flush_valid = 1'b1;
        bus.flush_target = 32'h300;
        step();
        idle();
        n_tests += 2;
        if (bus.pc_out !== EXC_V) begin n_fail++; $display("FAIL exc_pc got %h want %h", bus.pc_out, EXC_V); end
        if (bus.ras_empty !== 1'b1) begin n_fail++; $display("FAIL exc_empty got %b want 1", bus.ras_empty); end
    endtask

    task automatic test_call_ret();
        logic [31:0] want;
        goto(32'h100);
        bus.call_valid = 1'b1;
        bus.call_target = 32'h400;
        step();
        idle();
        n_tests++;
        if (bus.pc_out !== 32'h400) begin n_fail++; $display("FAIL call_pc got %h want 00000400", bus.pc_out); end
        step();
        bus.ret_valid = 1'b1;
        step();
        idle();
`ifdef PC_RAS_EN
        want = 32'h104;
`else
        want = 32'h408;
`endif
        n_tests++;
        if (bus.pc_out !== want) begin n_fail++; $display("FAIL ret_pc got %h want %h", bus.pc_out, want); end
    endtask

    task automatic test_nested();
        logic [31:0] ret_want[5];
        ret_want = '{32'h2304, 32'h2204, 32'h2104, 32'h2004, 32'h2008};
        goto(32'h1000);
        for (int i = 0; i < 5; i++) begin
            bus.call_valid = 1'b1;
            bus.call_target = 32'h2000 + 32'(i) * 32'h100;
            step();
            n_tests += 2;
            if (bus.pc_out !== exp_pc) begin n_fail++; $display("FAIL nest_call[%0d] got %h want %h", i, bus.pc_out, exp_pc); end
            if (bus.ras_full !== (ras_q.size() == DEPTH)) begin n_fail++; $display("FAIL nest_full[%0d] got %b want %b", i, bus.ras_full, ras_q.size() == DEPTH); end
        end
        idle();
        for (int i = 0; i < 5; i++) begin
            bus.ret_valid = 1'b1;
            step();
            n_tests += 2;
            if (bus.pc_out !== exp_pc) begin n_fail++; $display("FAIL nest_ret[%0d] got %h want %h", i, bus.pc_out, exp_pc); end
            if (bus.ras_empty !== (ras_q.size() == 0)) begin n_fail++; $display("FAIL nest_empty[%0d] got %b want %b", i, bus.ras_empty, ras_q.size() == 0); end
`ifdef PC_RAS_EN
            n_tests++;
            if (bus.pc_out !== ret_want[i]) begin n_fail++; $display("FAIL nest_addr[%0d] got %h want %h", i, bus.pc_out, ret_want[i]); end
`endif
        end
        idle();
    endtask

    task automatic test_back_to_back();
        goto(32'h500);
        bus.call_valid = 1'b1;
        bus.call_target = 32'h600;
        step();
        bus.ret_valid = 1'b1;
        bus.call_target = 32'h700;
        step();
        n_tests++;
        if (bus.pc_out !== exp_pc) begin n_fail++; $display("FAIL b2b_callret got %h want %h", bus.pc_out, exp_pc); end
        idle();
        bus.ret_valid = 1'b1;
        step();
        idle();
        n_tests++;
        if (bus.pc_out !== exp_pc) begin n_fail++; $display("FAIL b2b_ret got %h want %h", bus.pc_out, exp_pc); end
    endtask

    task automatic test_wrap_reset();
        goto(32'hFFFF_FFFC);
        step();
        n_tests++;
        if (bus.pc_out !== 32'h0) begin n_fail++; $display("FAIL wrap got %h want 00000000", bus.pc_out); end
        bus.call_valid = 1'b1;
        bus.call_target = 32'h50;
        step();
        idle();
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        n_tests += 3;
        if (bus.pc_out !== RST_V) begin n_fail++; $display("FAIL async_pc got %h want %h", bus.pc_out, RST_V); end
        if (bus.pc_valid !== 1'b0) begin n_fail++; $display("FAIL async_valid got %b want 0", bus.pc_valid); end
        if (bus.ras_empty !== 1'b1) begin n_fail++; $display("FAIL async_empty got %b want 1", bus.ras_empty); end
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            bus.exc_valid    = $urandom_range(0, 29) == 0;
            bus.flush_valid  = $urandom_range(0, 11) == 0;
            bus.enable       = $urandom_range(0, 6) != 0;
            bus.call_valid   = $urandom_range(0, 3) == 0;
            bus.ret_valid    = $urandom_range(0, 3) == 0;
            bus.flush_target = $urandom;
            bus.call_target  = $urandom;
            step();
            n_tests += 4;
            if (bus.pc_out !== exp_pc) begin n_fail++; $display("FAIL rnd_pc[%0d] got %h want %h", i, bus.pc_out, exp_pc); end
            if (bus.pc_valid !== exp_valid) begin n_fail++; $display("FAIL rnd_valid[%0d] got %b want %b", i, bus.pc_valid, exp_valid); end
            if (bus.ras_empty !== (ras_q.size() == 0)) begin n_fail++; $display("FAIL rnd_empty[%0d] got %b want %b", i, bus.ras_empty, ras_q.size() == 0); end
            if (bus.ras_full !== (ras_q.size() == DEPTH)) begin n_fail++; $display("FAIL rnd_full[%0d] got %b want %b", i, bus.ras_full, ras_q.size() == DEPTH); end
        end
        idle();
    endtask

    initial begin
        test_reset();
        test_stall_flush();
        test_exc();
        test_call_ret();
        test_nested();
        test_back_to_back();
        test_wrap_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
